// File: rtl/fft_pair_demux.sv
// -----------------------------------------------------------------------------
// fft_pair_demux
// Streaming radix-2 pair former. It takes one complex sample per accepted beat
// and emits butterfly operand pairs (x[j], x[j+S]) for each group of 2*S samples.
// The twiddle that arrives alongside x[j+S] is carried out with the pair.
// S = 2^stride_log2 is latched at each group start and clamped to MAX_STRIDE_LOG2.
//
// Optional feature: define FFT_PAIR_DEMUX_ERR_EN to add err_o. err_o is a sticky
// flag for stride misuse: a stride change inside a group, or an out-of-range
// stride at a latch point.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous clear of group position and output register
//   stride_log2           requested log2 stride (clamped)
//   in_valid / in_ready   input handshake
//   re_i, im_i            input sample
//   cos_i, sin_i          twiddle, used on second-half beats only
//   out_valid / out_ready output handshake (single-entry output register)
//   re_o1, im_o1          first operand x[j]
//   re_o2, im_o2          second operand x[j+S]
//   cos_o, sin_o          twiddle captured with x[j+S]
//   out_idx               pair index j within the group
//   out_last              final pair of the group (j = S-1)
//   err_o                 sticky stride error (FFT_PAIR_DEMUX_ERR_EN only)
// -----------------------------------------------------------------------------
module fft_pair_demux #(
    parameter int unsigned BIT_WIDTH       = 16,
    parameter int unsigned TW_WIDTH        = 14,
    parameter int unsigned MAX_STRIDE_LOG2 = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clr,
    input  logic [$clog2(MAX_STRIDE_LOG2+1)-1:0]   stride_log2,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BIT_WIDTH-1:0]                   re_i,
    input  logic [BIT_WIDTH-1:0]                   im_i,
    input  logic [TW_WIDTH-1:0]                    cos_i,
    input  logic [TW_WIDTH-1:0]                    sin_i,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BIT_WIDTH-1:0]                   re_o1,
    output logic [BIT_WIDTH-1:0]                   im_o1,
    output logic [BIT_WIDTH-1:0]                   re_o2,
    output logic [BIT_WIDTH-1:0]                   im_o2,
    output logic [TW_WIDTH-1:0]                    cos_o,
    output logic [TW_WIDTH-1:0]                    sin_o,
    output logic [MAX_STRIDE_LOG2-1:0]             out_idx,
    output logic                                   out_last
`ifdef FFT_PAIR_DEMUX_ERR_EN
    ,
    output logic                                   err_o
`endif
);

    localparam int unsigned SLW   = $clog2(MAX_STRIDE_LOG2 + 1);
    localparam int unsigned PW    = MAX_STRIDE_LOG2;
    localparam int unsigned PW1   = PW + 1;
    localparam int unsigned DEPTH = 1 << MAX_STRIDE_LOG2;
    localparam int unsigned DW    = 2 * BIT_WIDTH;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    state_t             state;
    logic [PW-1:0]      pos;
    logic [SLW-1:0]     act_log2;
    logic [DW-1:0]      mem_q [DEPTH];

    logic [SLW-1:0]     stride_clamped_c;
    logic               accept_c;
    logic               group_start_c;
    logic [SLW-1:0]     eff_log2_c;
    logic [PW1-1:0]     span_c;
    logic [PW-1:0]      last_pos_c;
    logic               pos_last_c;
    logic [DW-1:0]      mem_rd_c;

    // Requested stride, clamped to the buffer capacity
    assign stride_clamped_c = (stride_log2 > SLW'(MAX_STRIDE_LOG2)) ?
                              SLW'(MAX_STRIDE_LOG2) : stride_log2;

    // FILL never stalls; PAIR stalls only when a pending pair cannot leave
    assign in_ready      = (state == FILL) || !out_valid || out_ready;
    assign accept_c      = in_valid && in_ready;
    assign group_start_c = (state == FILL) && (pos == '0);

    // The group-start beat already belongs to the newly latched stride
    assign eff_log2_c = group_start_c ? stride_clamped_c : act_log2;
    assign span_c     = PW1'(1) << eff_log2_c;
    assign last_pos_c = PW'(span_c - PW1'(1));
    assign pos_last_c = (pos == last_pos_c);
    assign mem_rd_c   = mem_q[pos];

    // First-half sample store; contents need no reset
    always_ff @(posedge clk) begin
        if (accept_c && (state == FILL) && !clr) begin
            mem_q[pos] <= {re_i, im_i};
        end
    end

    // Group sequencing and the single-entry output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            pos       <= '0;
            act_log2  <= '0;
            out_valid <= 1'b0;
            re_o1     <= '0;
            im_o1     <= '0;
            re_o2     <= '0;
            im_o2     <= '0;
            cos_o     <= '0;
            sin_o     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            state     <= FILL;
            pos       <= '0;
            out_valid <= 1'b0;
            re_o1     <= '0;
            im_o1     <= '0;
            re_o2     <= '0;
            im_o2     <= '0;
            cos_o     <= '0;
            sin_o     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept_c) begin
                if (group_start_c) begin
                    act_log2 <= stride_clamped_c;
                end
                if (pos_last_c) begin
                    pos   <= '0;
                    state <= (state == FILL) ? PAIR : FILL;
                end else begin
                    pos <= pos + PW'(1);
                end
            end

            if (accept_c && (state == PAIR)) begin
                re_o1     <= mem_rd_c[DW-1:BIT_WIDTH];
                im_o1     <= mem_rd_c[BIT_WIDTH-1:0];
                re_o2     <= re_i;
                im_o2     <= im_i;
                cos_o     <= cos_i;
                sin_o     <= sin_i;
                out_idx   <= pos;
                out_last  <= pos_last_c;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FFT_PAIR_DEMUX_ERR_EN
    // Sticky stride-misuse flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (clr) begin
            err_o <= 1'b0;
        end else if (accept_c) begin
            if (group_start_c) begin
                if (stride_log2 > SLW'(MAX_STRIDE_LOG2)) begin
                    err_o <= 1'b1;
                end
            end else if (stride_clamped_c != act_log2) begin
                err_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_pair_demux.sv
// -----------------------------------------------------------------------------
// tb_fft_pair_demux
// Directed bench for fft_pair_demux. Expected pairs are queued by hand. They are
// compared at every output transfer, and inline checks cover latency, hold and
// reset/clr behaviour.
// -----------------------------------------------------------------------------
module tb_fft_pair_demux;

    localparam int unsigned BW  = 16;
    localparam int unsigned TW  = 14;
    localparam int unsigned MS  = 4;
    localparam int unsigned SLW = $clog2(MS + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr = 1'b0;
    logic [SLW-1:0]        stride_log2 = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [BW-1:0]  re_i = '0;
    logic signed [BW-1:0]  im_i = '0;
    logic signed [TW-1:0]  cos_i = '0;
    logic signed [TW-1:0]  sin_i = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [BW-1:0]  re_o1, im_o1, re_o2, im_o2;
    logic signed [TW-1:0]  cos_o, sin_o;
    logic [MS-1:0]         out_idx;
    logic                  out_last;
`ifdef FFT_PAIR_DEMUX_ERR_EN
    logic                  err_o;
`endif

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        int re1;
        int re2;
        int cw;
        int idx;
        int last;
    } pair_t;

    pair_t exp_q[$];

    fft_pair_demux #(
        .BIT_WIDTH      (BW),
        .TW_WIDTH       (TW),
        .MAX_STRIDE_LOG2(MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .stride_log2(stride_log2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .re_i       (re_i),
        .im_i       (im_i),
        .cos_i      (cos_i),
        .sin_i      (sin_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .re_o1      (re_o1),
        .im_o1      (im_o1),
        .re_o2      (re_o2),
        .im_o2      (im_o2),
        .cos_o      (cos_o),
        .sin_o      (sin_o),
        .out_idx    (out_idx),
        .out_last   (out_last)
`ifdef FFT_PAIR_DEMUX_ERR_EN
        ,
        .err_o      (err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_pair(input int re1, input int re2, input int cw,
                            input int idx, input int last);
        pair_t p;
        p.re1 = re1; p.re2 = re2; p.cw = cw; p.idx = idx; p.last = last;
        exp_q.push_back(p);
    endtask

    // Present one sample (im = re+100, sin = -cos) and return one step after it is accepted
    task automatic send(input int re, input int cw);
        logic acc;
        in_valid = 1'b1;
        re_i  = BW'(re);
        im_i  = BW'(re + 100);
        cos_i = TW'(cw);
        sin_i = TW'(-cw);
        for (int n = 0; n < 60; n++) begin
            #2;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        check("send_timeout", 32'(re), -1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Scoreboard: compare each pair as it transfers
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pair", exp_q.size(), 1);
            end else begin
                pair_t p;
                p = exp_q.pop_front();
                check("re_o1", re_o1, p.re1);
                check("im_o1", im_o1, p.re1 + 100);
                check("re_o2", re_o2, p.re2);
                check("im_o2", im_o2, p.re2 + 100);
                check("cos_o", cos_o, p.cw);
                check("sin_o", sin_o, -p.cw);
                check("out_idx", 32'(out_idx), p.idx);
                check("out_last", 32'(out_last), p.last);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_re_o1", re_o1, 0);
        check("rst_cos_o", cos_o, 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_out_last", 32'(out_last), 0);
`ifdef FFT_PAIR_DEMUX_ERR_EN
        check("rst_err", 32'(err_o), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // S=1: adjacent pairs, one clock after the second operand
        stride_log2 = 3'd0;
        exp_pair(1, 2, 1, 0, 1);
        exp_pair(3, 4, 3, 0, 1);
        send(1, 0);
        check("t1_no_pair_yet", 32'(out_valid), 0);
        send(2, 1);
        check("t1_lat_valid", 32'(out_valid), 1);
        check("t1_lat_re1", re_o1, 1);
        check("t1_lat_re2", re_o2, 2);
        send(3, 2);
        send(4, 3);
        check("t1_lat2_re1", re_o1, 3);
        check("t1_lat2_re2", re_o2, 4);
        drain();

        // S=4: twiddle from second-half beats
        stride_log2 = 3'd2;
        exp_pair(10, 14, 4, 0, 0);
        exp_pair(11, 15, 5, 1, 0);
        exp_pair(12, 16, 6, 2, 0);
        exp_pair(13, 17, 7, 3, 1);
        for (int i = 0; i < 8; i++) send(10 + i, i);
        drain();

        // S=2 with three cycles of output backpressure
        stride_log2 = 3'd1;
        exp_pair(20, 22, 2, 0, 0);
        exp_pair(21, 23, 3, 1, 1);
        exp_pair(24, 26, 6, 0, 0);
        exp_pair(25, 27, 7, 1, 1);
        fork
            begin
                for (int i = 0; i < 8; i++) send(20 + i, i);
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 40 && !out_valid; n++) begin
                    @(posedge clk);
                    #1;
                end
                check("t3_first_valid", 32'(out_valid), 1);
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    check("t3_in_ready_low", 32'(in_ready), 0);
                    check("t3_hold_valid", 32'(out_valid), 1);
                    check("t3_hold_re1", re_o1, 20);
                    check("t3_hold_re2", re_o2, 22);
                    check("t3_hold_idx", 32'(out_idx), 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Stride change mid-group applies only from the next group
        stride_log2 = 3'd1;
        exp_pair(30, 32, 2, 0, 0);
        exp_pair(31, 33, 3, 1, 1);
        exp_pair(40, 44, 4, 0, 0);
        exp_pair(41, 45, 5, 1, 0);
        exp_pair(42, 46, 6, 2, 0);
        exp_pair(43, 47, 7, 3, 1);
        send(30, 0);
        stride_log2 = 3'd2;
        send(31, 1);
        send(32, 2);
        send(33, 3);
        for (int i = 0; i < 8; i++) send(40 + i, i);
        drain();
`ifdef FFT_PAIR_DEMUX_ERR_EN
        check("t4_err_set", 32'(err_o), 1);
`endif

        // Out-of-range stride clamps to S=16
        stride_log2 = 3'd7;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
`ifdef FFT_PAIR_DEMUX_ERR_EN
        check("t5_err_clr", 32'(err_o), 0);
`endif
        for (int j = 0; j < 16; j++) exp_pair(100 + j, 116 + j, 16 + j, j, (j == 15) ? 1 : 0);
        for (int i = 0; i < 32; i++) send(100 + i, i);
        drain();
`ifdef FFT_PAIR_DEMUX_ERR_EN
        check("t5_err_clamp", 32'(err_o), 1);
`endif

        // clr after 3 FILL beats drops them and the coincident sample
        stride_log2 = 3'd2;
        send(200, 0);
        send(201, 0);
        send(202, 0);
        clr = 1'b1;
        in_valid = 1'b1;
        re_i = BW'(203);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_valid", 32'(out_valid), 0);
        check("t6_clr_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(210 + i, i);
        in_valid = 1'b0;
        check("t6_restart_valid", 32'(out_valid), 1);
        check("t6_restart_re1", re_o1, 210);
        check("t6_restart_re2", re_o2, 214);
        check("t6_restart_idx", 32'(out_idx), 0);

        // Async reset mid-PAIR
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_re1", re_o1, 0);
        check("t6_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        stride_log2 = 3'd1;
        exp_pair(220, 222, 2, 0, 0);
        exp_pair(221, 223, 3, 1, 1);
        for (int i = 0; i < 4; i++) send(220 + i, i);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
